// File: rtl/ram_block_reader.sv
// ram_block_reader: credit-limited streaming reader for a synchronous RAM read port.
// It walks a contiguous word range, captures q after the RAM latency into a
// small skid FIFO, and presents the words on a valid/ready stream.
// Optional build macro RDR_CHECKSUM_EN adds a modular sum of the delivered words.
module ram_block_reader #(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic [DATA_W-1:0] q,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic [DATA_W-1:0] checksum
);

  // Word counters must hold 0..2^ADDR_W.
  localparam int unsigned LEN_W  = ADDR_W + 1;
  // Tag pipe covers the rdaddress register stage plus the RAM read latency.
  localparam int unsigned PIPE_D = RD_LAT + 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SUM_W  = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_d;

  logic [ADDR_W-1:0]  ptr;
  logic [ADDR_W-1:0]  ptr_d;
  logic [ADDR_W-1:0]  ptr_src;
  logic [LEN_W-1:0]   issue_cnt;
  logic [LEN_W-1:0]   issue_cnt_d;
  logic [LEN_W-1:0]   icnt_src;
  logic [LEN_W-1:0]   deliver_cnt;
  logic [LEN_W-1:0]   deliver_cnt_d;

  logic [PIPE_D-1:0]  pipe;
  logic [SUM_W-1:0]   inflight;

  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic [CNT_W-1:0]   fifo_cnt_d;

  logic               load;
  logic               issue;
  logic               push;
  logic               pop;
  logic               credit_ok;

  // Number of reads issued whose data has not yet reached the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(PIPE_D); i++) begin
      inflight = inflight + SUM_W'(pipe[i]);
    end
  end

  // A tag leaving the pipe means q holds that read's word this cycle.
  assign push      = pipe[PIPE_D-1];
  assign pop       = m_valid & m_ready;
  assign credit_ok = (SUM_W'(fifo_cnt) + inflight) < SUM_W'(FIFO_DEPTH);

  // Next-state, issue decision and counter updates.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    issue   = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          if (length == '0) begin
            state_d = DONE;
          end else begin
            // FIFO and pipe are empty in IDLE, so the first read needs no credit check.
            state_d = RUN;
            issue   = 1'b1;
          end
        end
      end
      RUN: begin
        if (issue_cnt == '0) begin
          state_d = DRAIN;
        end else if (credit_ok) begin
          issue = 1'b1;
        end
      end
      DRAIN: begin
        if (deliver_cnt == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ptr_src       = load ? base_addr : ptr;
    icnt_src      = load ? length : issue_cnt;
    ptr_d         = issue ? ptr_src + ADDR_W'(1) : ptr_src;
    issue_cnt_d   = issue ? icnt_src - LEN_W'(1) : icnt_src;
    deliver_cnt_d = load ? length
                  : (pop ? deliver_cnt - LEN_W'(1) : deliver_cnt);
    fifo_cnt_d    = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
  end

  // Control state, counters, read issue and registered stream/status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= '0;
      issue_cnt   <= '0;
      deliver_cnt <= '0;
      pipe        <= '0;
      rdaddress   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      issue_cnt   <= issue_cnt_d;
      deliver_cnt <= deliver_cnt_d;
      pipe        <= {pipe[PIPE_D-2:0], issue};
      if (issue) begin
        rdaddress <= ptr_src;
      end
      busy        <= (state_d != IDLE);
      done        <= (state == DONE);
      m_valid     <= (fifo_cnt_d != '0);
      m_last      <= (fifo_cnt_d != '0) && (deliver_cnt_d == LEN_W'(1));
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_cnt <= fifo_cnt_d;
    end
  end

  // FIFO storage; contents are don't-care while the occupancy is zero.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= q;
    end
  end

  assign m_data = mem[rd_ptr];

`ifdef RDR_CHECKSUM_EN
  // Modular sum of every word accepted downstream for the current command.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if (load) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum + m_data;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule
